ldpc_out_pack: RTL and testbench
================================

Name: ldpc_out_pack

Overview:
- Downstream of the LDPC decoder; consumes its serial hard-decision stream (decoder data_out/sync_out) for 9216-bit codewords.
- Keeps only the systematic information bits (first K bits of each codeword), packs them MSB-first into bytes and buffers them in a small FIFO.
- Presents a valid/ready byte stream with start/end-of-frame markers to the CMMB demux/MAC layer.

Parameters:
- FIFO_DEP, 16, FIFO depth in bytes (power of 2).
- FIFO_AW, 4, FIFO address width; must equal log2(FIFO_DEP).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- bit_in  in  1  decoded hard bit (decoder data_out).
- sync_in  in  1  bit_in valid (decoder sync_out); one bit per cycle while high.
- rate  in  1  code rate: 0 = 1/2 (K=4608), 1 = 3/4 (K=6912).
- byte_out  out  8  packed info byte; first received bit in bit 7.
- byte_valid  out  1  byte_out valid.
- byte_ready  in  1  consumer accepts byte when byte_valid && byte_ready.
- byte_sop  out  1  qualifies byte_out as first byte of a frame.
- byte_eop  out  1  qualifies byte_out as last byte of a frame.
- ovf  out  1  sticky FIFO overflow flag.
- frame_err  out  1  one-cycle frame-length error pulse (see Optional Feature).

Behaviour:
- Reset: byte_out=0, byte_valid=0, byte_sop=0, byte_eop=0, ovf=0, frame_err=0. FIFO is emptied, bit counter=0, state=IDLE. Asserting reset mid-frame discards all partial and buffered data.
- bit_cnt is 14 bits and counts bits 0..9215 of the current frame. k_lat latches rate on the first bit of each frame and holds it for the whole frame.
- States:
  - IDLE: first cycle with sync_in=1 -> INFO; that bit is bit 0.
  - INFO: bits 0..K-1 shift into an 8-bit pack register. Every 8th bit writes {sop,eop,byte} to the FIFO on the following edge. sop is set on byte 0; eop is set on byte K/8-1 (575 for rate 1/2, 863 for rate 3/4). Bit K-1 -> PARITY.
  - PARITY: bits K..9215 are counted and discarded. Bit 9215 -> IDLE, or straight to INFO if sync_in is still high on the next cycle. Back-to-back frames need no gap, and rate is resampled for the new frame.
- sync_in low mid-frame (INFO or PARITY): frame aborted, go to IDLE. The partial byte is discarded, no eop is written, and bytes already in the FIFO are kept.
- sync_in gaps are not permitted inside a frame; any low cycle is treated as an abort.
- Latency: byte_valid rises on the 2nd rising edge after the edge that samples the byte's 8th bit, provided the FIFO was empty.
- FIFO is show-ahead: byte_out/byte_sop/byte_eop are valid whenever byte_valid=1, and they hold stable until accepted.
- FIFO full at write time: the byte is dropped and ovf is set and held until reset. The decoder cannot be stalled.
- Simultaneous read and write while full: the read frees a slot and the write succeeds, with no overflow.
- The FIFO entry is 10 bits wide: {sop, eop, byte}.

Optional Feature:
- Macro: LDPC_PACK_LEN_CHK_EN.
- Defined: frame_err pulses high for one cycle after sync_in falls in INFO or PARITY (short frame). It also pulses for an abort while the pack register holds a partial byte.
- Not defined: abort behaviour is unchanged, and frame_err is held at 0.

Decomposition:
- Package ldpc_pkg holds:
  - constants LDPC_N=9216, LDPC_K_R12=4608, LDPC_K_R34=6912, LDPC_CNT_W=14;
  - state encoding IDLE/INFO/PARITY.
- One sub-module, ldpc_byte_fifo: a synchronous show-ahead FIFO, 10-bit wide, depth FIFO_DEP, with full/empty outputs and the same clock and reset.

Test Plan:
- Rate 0 frame, bit_in alternating 1,0, byte_ready=1 -> 576 bytes of 0xAA; sop only on byte 0, eop only on byte 575; parity bits produce no output; ovf=0.
- Rate 1 frame, info bits = binary count of the byte index (bytes 0x00,0x01,...) -> 864 bytes, byte n = n mod 256, eop on byte 863.
- Two back-to-back frames (rate 0, then rate 1) with sync_in continuously high for 18432 cycles -> 576+864 bytes; rate is correctly resampled, with sop and eop at each frame.
- byte_ready held low for the entire rate 0 frame with FIFO_DEP=16 -> first 16 bytes retained, ovf=1 sticky; releasing ready drains exactly 16 bytes, the first carrying sop.
- sync_in dropped after 100 bits -> 12 bytes output, no eop, IDLE. With LDPC_PACK_LEN_CHK_EN, frame_err pulses once; without it, frame_err stays 0.
- reset_n asserted at bit 3000 of a frame -> all outputs return to their reset values immediately and the FIFO is empty. The next full frame decodes correctly.

Source files
------------

// File: rtl/ldpc_pkg.sv
// ============================================================================
//  Module      : ldpc_pkg
//  Description : Shared constants, state encoding and FIFO entry layout for
//                the LDPC output packer (ldpc_out_pack).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ldpc_pkg;

    // Codeword geometry
    localparam int LDPC_N     = 9216;  // bits per codeword
    localparam int LDPC_K_R12 = 4608;  // information bits, rate 1/2
    localparam int LDPC_K_R34 = 6912;  // information bits, rate 3/4
    localparam int LDPC_CNT_W = 14;    // wide enough to count 0..LDPC_N-1

    // Frame tracking state
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        INFO   = 2'd1,
        PARITY = 2'd2
    } ldpc_state_e;

    // One buffered byte together with its frame markers
    typedef struct packed {
        logic       sop;
        logic       eop;
        logic [7:0] data;
    } ldpc_fifo_entry_t;

    // Number of information bits for a code-rate select (0 = 1/2, 1 = 3/4)
    function automatic logic [LDPC_CNT_W-1:0] info_len(input logic rate);
        return rate ? LDPC_CNT_W'(LDPC_K_R34) : LDPC_CNT_W'(LDPC_K_R12);
    endfunction

endpackage

`default_nettype wire

// File: rtl/ldpc_out_pack_if.sv
// ============================================================================
//  Module      : ldpc_out_pack_if
//  Description : Valid/ready byte stream with start/end-of-frame markers.
//  Revision    : 1.0 - initial release
//
//  Signals:
//    byte_out   [7:0] packed information byte, first received bit in bit 7
//    byte_valid       byte_out/byte_sop/byte_eop are valid
//    byte_ready       consumer accepts the byte when byte_valid && byte_ready
//    byte_sop         byte is the first byte of a frame
//    byte_eop         byte is the last byte of a frame
//  Modports:
//    master - byte producer (the packer)
//    slave  - byte consumer (demux/MAC)
// ============================================================================
`default_nettype none

interface ldpc_out_pack_if;

    logic [7:0] byte_out;
    logic       byte_valid;
    logic       byte_ready;
    logic       byte_sop;
    logic       byte_eop;

    modport master (
        output byte_out,
        output byte_valid,
        output byte_sop,
        output byte_eop,
        input  byte_ready
    );

    modport slave (
        input  byte_out,
        input  byte_valid,
        input  byte_sop,
        input  byte_eop,
        output byte_ready
    );

endinterface

`default_nettype wire

// File: rtl/ldpc_byte_fifo.sv
// ============================================================================
//  Module      : ldpc_byte_fifo
//  Description : Synchronous show-ahead FIFO, 10-bit entries {sop,eop,byte}.
//                The head entry sits in an output register so the read side
//                is fully registered; total capacity (memory + output
//                register) is FIFO_DEP entries.
//  Revision    : 1.0 - initial release
//
//  Ports:
//    clk      in   clock
//    reset_n  in   asynchronous active-low reset, empties the FIFO
//    wr_en    in   write request (ignored when full unless a read frees a slot)
//    wr_data  in   entry to write
//    rd_en    in   pop the head entry (ignored when empty)
//    rd_data  out  head entry, valid while empty is low
//    full     out  FIFO_DEP entries stored
//    empty    out  no entry available
// ============================================================================
`default_nettype none

module ldpc_byte_fifo #(
    parameter int FIFO_DEP = 16,
    parameter int FIFO_AW  = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       wr_en,
    input  logic [9:0] wr_data,
    input  logic       rd_en,
    output logic [9:0] rd_data,
    output logic       full,
    output logic       empty
);

    localparam logic [FIFO_AW:0] DEP_CNT = (FIFO_AW+1)'(FIFO_DEP);

    logic [9:0]         mem_q [FIFO_DEP];
    logic [FIFO_AW-1:0] wr_ptr_q,  wr_ptr_d;
    logic [FIFO_AW-1:0] rd_ptr_q,  rd_ptr_d;
    logic [FIFO_AW:0]   mem_cnt_q, mem_cnt_d;
    logic               out_valid_q, out_valid_d;
    logic [9:0]         out_data_q,  out_data_d;

    logic [FIFO_AW:0]   occ;
    logic               rd_fire;
    logic               wr_fire;
    logic               load;

    always_comb begin
        occ         = mem_cnt_q + {{FIFO_AW{1'b0}}, out_valid_q};
        full        = (occ == DEP_CNT);
        empty       = !out_valid_q;
        rd_fire     = rd_en && out_valid_q;
        // A read in the same cycle frees a slot, so a write while full succeeds
        wr_fire     = wr_en && (!full || rd_fire);
        // Refill the output register whenever it is free or being drained
        load        = (mem_cnt_q != '0) && (!out_valid_q || rd_fire);

        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        mem_cnt_d   = mem_cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;

        if (wr_fire) begin
            wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
        end
        if (load) begin
            rd_ptr_d    = rd_ptr_q + FIFO_AW'(1);
            out_valid_d = 1'b1;
            out_data_d  = mem_q[rd_ptr_q];
        end else if (rd_fire) begin
            out_valid_d = 1'b0;
        end

        case ({wr_fire, load})
            2'b10:   mem_cnt_d = mem_cnt_q + (FIFO_AW+1)'(1);
            2'b01:   mem_cnt_d = mem_cnt_q - (FIFO_AW+1)'(1);
            default: mem_cnt_d = mem_cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            mem_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            mem_cnt_q   <= mem_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    // Storage array carries no reset; occupancy tracking guards every read
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_data = out_data_q;

endmodule

`default_nettype wire

// File: rtl/ldpc_out_pack.sv
// ============================================================================
//  Module      : ldpc_out_pack
//  Description : Takes the serial hard-decision stream of the LDPC decoder
//                (9216-bit codewords), keeps the first K information bits,
//                packs them MSB-first into bytes and buffers them in a small
//                FIFO presented as a valid/ready byte stream with SOP/EOP.
//  Revision    : 1.0 - initial release
//
//  Optional build macro:
//    LDPC_PACK_LEN_CHK_EN - when defined, frame_err pulses for one cycle after
//                           a frame is aborted by sync_in dropping in INFO or
//                           PARITY. When undefined frame_err is tied to 0.
//
//  Ports:
//    clk        in   system clock
//    reset_n    in   asynchronous active-low reset
//    bit_in     in   decoded hard bit
//    sync_in    in   bit_in valid, one bit per cycle while high
//    rate       in   0 = rate 1/2 (K=4608), 1 = rate 3/4 (K=6912)
//    out_if     --   byte stream (master side): byte_out, byte_valid,
//                    byte_ready, byte_sop, byte_eop
//    ovf        out  sticky FIFO overflow flag
//    frame_err  out  one-cycle frame-length error pulse
// ============================================================================
`default_nettype none

module ldpc_out_pack
    import ldpc_pkg::*;
#(
    parameter int FIFO_DEP = 16,
    parameter int FIFO_AW  = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   bit_in,
    input  logic                   sync_in,
    input  logic                   rate,
    ldpc_out_pack_if.master        out_if,
    output logic                   ovf,
    output logic                   frame_err
);

    ldpc_state_e             state_q,   state_d;
    logic [LDPC_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic                    k_lat_q,   k_lat_d;
    logic [7:0]              pack_q,    pack_d;
    logic                    wr_pend_q, wr_pend_d;
    logic                    wr_sop_q,  wr_sop_d;
    logic                    wr_eop_q,  wr_eop_d;
    logic                    ovf_q,     ovf_d;

    logic [LDPC_CNT_W-1:0]   k_last;
    logic                    bit_take;
    logic                    fifo_full;
    logic                    fifo_empty;
    ldpc_fifo_entry_t        fifo_wr;
    ldpc_fifo_entry_t        fifo_rd;

    // ------------------------------------------------------------------
    // Frame tracking and bit packing
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        k_lat_d   = k_lat_q;
        pack_d    = pack_q;
        wr_pend_d = 1'b0;
        wr_sop_d  = wr_sop_q;
        wr_eop_d  = wr_eop_q;
        bit_take  = 1'b0;

        // On bit 0 the rate has not been latched yet, so use it directly
        k_last = info_len((state_q == IDLE) ? rate : k_lat_q) - LDPC_CNT_W'(1);

        case (state_q)
            IDLE: begin
                // bit_cnt_q is always 0 here, so this is bit 0 of a new frame
                if (sync_in) begin
                    state_d   = INFO;
                    k_lat_d   = rate;
                    bit_take  = 1'b1;
                    bit_cnt_d = LDPC_CNT_W'(1);
                end
            end
            INFO: begin
                if (!sync_in) begin
                    state_d   = IDLE;
                    bit_cnt_d = '0;
                    pack_d    = '0;
                end else begin
                    bit_take  = 1'b1;
                    bit_cnt_d = bit_cnt_q + LDPC_CNT_W'(1);
                    if (bit_cnt_q == k_last) begin
                        state_d = PARITY;
                    end
                end
            end
            PARITY: begin
                if (!sync_in) begin
                    state_d   = IDLE;
                    bit_cnt_d = '0;
                    pack_d    = '0;
                end else if (bit_cnt_q == LDPC_CNT_W'(LDPC_N - 1)) begin
                    // IDLE accepts the next frame's bit 0 on the very next
                    // cycle, so back-to-back frames need no gap
                    state_d   = IDLE;
                    bit_cnt_d = '0;
                end else begin
                    bit_cnt_d = bit_cnt_q + LDPC_CNT_W'(1);
                end
            end
            default: begin
                state_d   = IDLE;
                bit_cnt_d = '0;
            end
        endcase

        if (bit_take) begin
            pack_d = {pack_q[6:0], bit_in};
            // 8th bit of a byte: queue the byte for the FIFO on the next edge
            if (bit_cnt_q[2:0] == 3'd7) begin
                wr_pend_d = 1'b1;
                wr_sop_d  = (bit_cnt_q[LDPC_CNT_W-1:3] == '0);
                wr_eop_d  = (bit_cnt_q == k_last);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            k_lat_q   <= 1'b0;
            pack_q    <= '0;
            wr_pend_q <= 1'b0;
            wr_sop_q  <= 1'b0;
            wr_eop_q  <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            k_lat_q   <= k_lat_d;
            pack_q    <= pack_d;
            wr_pend_q <= wr_pend_d;
            wr_sop_q  <= wr_sop_d;
            wr_eop_q  <= wr_eop_d;
            ovf_q     <= ovf_d;
        end
    end

    // ------------------------------------------------------------------
    // Byte FIFO
    // ------------------------------------------------------------------
    always_comb begin
        fifo_wr.sop  = wr_sop_q;
        fifo_wr.eop  = wr_eop_q;
        fifo_wr.data = pack_q;
        // A write is dropped only if full and no read frees a slot this cycle
        ovf_d = ovf_q || (wr_pend_q && fifo_full && !out_if.byte_ready);
    end

    ldpc_byte_fifo #(
        .FIFO_DEP (FIFO_DEP),
        .FIFO_AW  (FIFO_AW)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (wr_pend_q),
        .wr_data (fifo_wr),
        .rd_en   (out_if.byte_ready),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign out_if.byte_valid = !fifo_empty;
    assign out_if.byte_out   = fifo_rd.data;
    assign out_if.byte_sop   = fifo_rd.sop;
    assign out_if.byte_eop   = fifo_rd.eop;
    assign ovf               = ovf_q;

    // ------------------------------------------------------------------
    // Frame-length error
    // ------------------------------------------------------------------
`ifdef LDPC_PACK_LEN_CHK_EN
    logic frame_err_q, frame_err_d;

    // Any sync_in drop inside a frame is a short frame; this also covers an
    // abort with a partially filled pack register
    always_comb begin
        frame_err_d = (state_q != IDLE) && !sync_in;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= frame_err_d;
        end
    end

    assign frame_err = frame_err_q;
`else
    assign frame_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ldpc_out_pack.sv
// ============================================================================
//  Module      : tb_ldpc_out_pack
//  Description : Self-checking bench for ldpc_out_pack. Expected bytes are
//                queued as the stimulus bits are driven and compared when the
//                DUT hands a byte over.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ldpc_out_pack;
    import ldpc_pkg::*;

    localparam int FIFO_DEP = 16;
    localparam int FIFO_AW  = 4;

    logic clk = 1'b0;
    logic reset_n;
    logic bit_in;
    logic sync_in;
    logic rate;
    logic ovf;
    logic frame_err;

    ldpc_out_pack_if bus ();

    ldpc_out_pack #(
        .FIFO_DEP (FIFO_DEP),
        .FIFO_AW  (FIFO_AW)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bit_in    (bit_in),
        .sync_in   (sync_in),
        .rate      (rate),
        .out_if    (bus),
        .ovf       (ovf),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    int         n_vec = 0;
    int         n_err = 0;
    int         n_rx;
    logic [9:0] sb [$];

    // mode 0: every byte 0xAA (bits 1,0,1,0...); mode 1: byte n = n mod 256
    function automatic logic [7:0] pat_byte(input int mode, input int n);
        logic [31:0] nv;
        nv = n;
        if (mode == 0) return 8'hAA;
        return nv[7:0];
    endfunction

    task automatic drive(input logic b, input logic s, input logic r, input logic rdy);
        @(posedge clk);
        #1;
        bit_in         = b;
        sync_in        = s;
        rate           = r;
        bus.byte_ready = rdy;
        @(negedge clk);
    endtask

    // Drive bit i of a frame; rate is randomised after bit 0 so the latched
    // rate must be used for the rest of the frame
    task automatic frame_bit(input int mode, input logic frate, input int i,
                             input logic rdy, input bit keep);
        int         k;
        int         n;
        logic [7:0] pb;
        logic       b;
        logic       r;
        k  = frate ? LDPC_K_R34 : LDPC_K_R12;
        n  = i / 8;
        pb = pat_byte(mode, n);
        if (i < k) b = pb[7 - (i % 8)];
        else       b = 1'($urandom_range(0, 1));
        r = (i == 0) ? frate : 1'($urandom_range(0, 1));
        if (i < k && (i % 8) == 7 && keep)
            sb.push_back({(n == 0), (n == k / 8 - 1), pb});
        drive(b, 1'b1, r, rdy);
    endtask

    task automatic test_reset();
        reset_n        = 1'b0;
        bit_in         = 1'b0;
        sync_in        = 1'b0;
        rate           = 1'b0;
        bus.byte_ready = 1'b0;
        repeat (3) @(negedge clk);
        n_vec += 6;
        if (bus.byte_out !== 8'h00) begin n_err++; $display("FAIL reset_byte_out: got %h, required 00", bus.byte_out); end
        if (bus.byte_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b, required 0", bus.byte_valid); end
        if (bus.byte_sop !== 1'b0) begin n_err++; $display("FAIL reset_sop: got %b, required 0", bus.byte_sop); end
        if (bus.byte_eop !== 1'b0) begin n_err++; $display("FAIL reset_eop: got %b, required 0", bus.byte_eop); end
        if (ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b, required 0", ovf); end
        if (frame_err !== 1'b0) begin n_err++; $display("FAIL reset_frame_err: got %b, required 0", frame_err); end
        @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (2) drive(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_rate0();
        logic [9:0] act, exp;
        n_rx = 0;
        sb.delete();
        for (int c = 0; c < LDPC_N + 20; c++) begin
            if (c < LDPC_N) frame_bit(0, 1'b0, c, 1'b1, 1'b1);
            else            drive(1'b0, 1'b0, 1'b0, 1'b1);
            if (c == 9) begin
                n_vec++;
                if (bus.byte_valid !== 1'b0) begin n_err++; $display("FAIL rate0_latency_early: got valid %b, required 0", bus.byte_valid); end
            end
            if (c == 10) begin
                n_vec++;
                if (bus.byte_valid !== 1'b1) begin n_err++; $display("FAIL rate0_latency: got valid %b, required 1", bus.byte_valid); end
            end
            if (bus.byte_valid === 1'b1 && bus.byte_ready === 1'b1) begin
                act = {bus.byte_sop, bus.byte_eop, bus.byte_out};
                n_vec++;
                n_rx++;
                if (sb.size() == 0) begin
                    n_err++; $display("FAIL rate0_byte: got %h, required no byte", act);
                end else begin
                    exp = sb.pop_front();
                    if (act !== exp) begin n_err++; $display("FAIL rate0_byte #%0d: got %h, required %h", n_rx - 1, act, exp); end
                end
            end
        end
        n_vec += 3;
        if (n_rx !== 576) begin n_err++; $display("FAIL rate0_count: got %0d, required 576", n_rx); end
        if (sb.size() !== 0) begin n_err++; $display("FAIL rate0_pending: got %0d left, required 0", sb.size()); end
        if (ovf !== 1'b0) begin n_err++; $display("FAIL rate0_ovf: got %b, required 0", ovf); end
    endtask

    task automatic test_rate1();
        logic [9:0] act, exp;
        n_rx = 0;
        sb.delete();
        for (int c = 0; c < LDPC_N + 20; c++) begin
            if (c < LDPC_N) frame_bit(1, 1'b1, c, 1'b1, 1'b1);
            else            drive(1'b0, 1'b0, 1'b0, 1'b1);
            if (bus.byte_valid === 1'b1 && bus.byte_ready === 1'b1) begin
                act = {bus.byte_sop, bus.byte_eop, bus.byte_out};
                n_vec++;
                n_rx++;
                if (sb.size() == 0) begin
                    n_err++; $display("FAIL rate1_byte: got %h, required no byte", act);
                end else begin
                    exp = sb.pop_front();
                    if (act !== exp) begin n_err++; $display("FAIL rate1_byte #%0d: got %h, required %h", n_rx - 1, act, exp); end
                end
            end
        end
        n_vec += 3;
        if (n_rx !== 864) begin n_err++; $display("FAIL rate1_count: got %0d, required 864", n_rx); end
        if (sb.size() !== 0) begin n_err++; $display("FAIL rate1_pending: got %0d left, required 0", sb.size()); end
        if (ovf !== 1'b0) begin n_err++; $display("FAIL rate1_ovf: got %b, required 0", ovf); end
    endtask

    task automatic test_back_to_back();
        logic [9:0] act, exp;
        n_rx = 0;
        sb.delete();
        for (int c = 0; c < 2 * LDPC_N + 20; c++) begin
            if (c < LDPC_N)          frame_bit(0, 1'b0, c, 1'b1, 1'b1);
            else if (c < 2 * LDPC_N) frame_bit(1, 1'b1, c - LDPC_N, 1'b1, 1'b1);
            else                     drive(1'b0, 1'b0, 1'b0, 1'b1);
            if (bus.byte_valid === 1'b1 && bus.byte_ready === 1'b1) begin
                act = {bus.byte_sop, bus.byte_eop, bus.byte_out};
                n_vec++;
                n_rx++;
                if (sb.size() == 0) begin
                    n_err++; $display("FAIL b2b_byte: got %h, required no byte", act);
                end else begin
                    exp = sb.pop_front();
                    if (act !== exp) begin n_err++; $display("FAIL b2b_byte #%0d: got %h, required %h", n_rx - 1, act, exp); end
                end
            end
        end
        n_vec += 2;
        if (n_rx !== 1440) begin n_err++; $display("FAIL b2b_count: got %0d, required 1440", n_rx); end
        if (sb.size() !== 0) begin n_err++; $display("FAIL b2b_pending: got %0d left, required 0", sb.size()); end
    endtask

    task automatic test_overflow();
        logic [9:0] act, exp;
        n_rx = 0;
        sb.delete();
        for (int c = 0; c < LDPC_N; c++) begin
            frame_bit(0, 1'b0, c, 1'b0, (c / 8) < FIFO_DEP);
            if (bus.byte_valid === 1'b1 && bus.byte_ready === 1'b1) begin
                n_vec++; n_err++;
                $display("FAIL ovf_early_read: got a handshake, required none");
            end
        end
        n_vec += 3;
        if (ovf !== 1'b1) begin n_err++; $display("FAIL ovf_flag: got %b, required 1", ovf); end
        if (bus.byte_valid !== 1'b1) begin n_err++; $display("FAIL ovf_valid: got %b, required 1", bus.byte_valid); end
        if (bus.byte_sop !== 1'b1) begin n_err++; $display("FAIL ovf_head_sop: got %b, required 1", bus.byte_sop); end
        for (int c = 0; c < 40; c++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b1);
            if (bus.byte_valid === 1'b1 && bus.byte_ready === 1'b1) begin
                act = {bus.byte_sop, bus.byte_eop, bus.byte_out};
                n_vec++;
                n_rx++;
                if (sb.size() == 0) begin
                    n_err++; $display("FAIL ovf_drain: got %h, required no byte", act);
                end else begin
                    exp = sb.pop_front();
                    if (act !== exp) begin n_err++; $display("FAIL ovf_drain #%0d: got %h, required %h", n_rx - 1, act, exp); end
                end
            end
        end
        n_vec += 3;
        if (n_rx !== FIFO_DEP) begin n_err++; $display("FAIL ovf_count: got %0d, required %0d", n_rx, FIFO_DEP); end
        if (sb.size() !== 0) begin n_err++; $display("FAIL ovf_pending: got %0d left, required 0", sb.size()); end
        if (ovf !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %b, required 1", ovf); end
    endtask

    task automatic test_abort();
        logic [9:0] act, exp;
        int         n_ferr;
        int         exp_ferr;
        n_rx   = 0;
        n_ferr = 0;
        sb.delete();
`ifdef LDPC_PACK_LEN_CHK_EN
        exp_ferr = 1;
`else
        exp_ferr = 0;
`endif
        for (int c = 0; c < 130; c++) begin
            if (c < 100) frame_bit(0, 1'b0, c, 1'b1, 1'b1);
            else         drive(1'b0, 1'b0, 1'b0, 1'b1);
            if (frame_err === 1'b1) n_ferr++;
            if (bus.byte_valid === 1'b1 && bus.byte_ready === 1'b1) begin
                act = {bus.byte_sop, bus.byte_eop, bus.byte_out};
                n_vec++;
                n_rx++;
                if (sb.size() == 0) begin
                    n_err++; $display("FAIL abort_byte: got %h, required no byte", act);
                end else begin
                    exp = sb.pop_front();
                    if (act !== exp) begin n_err++; $display("FAIL abort_byte #%0d: got %h, required %h", n_rx - 1, act, exp); end
                end
            end
        end
        n_vec += 3;
        if (n_rx !== 12) begin n_err++; $display("FAIL abort_count: got %0d, required 12", n_rx); end
        if (sb.size() !== 0) begin n_err++; $display("FAIL abort_pending: got %0d left, required 0", sb.size()); end
        if (n_ferr !== exp_ferr) begin n_err++; $display("FAIL abort_frame_err: got %0d pulse cycles, required %0d", n_ferr, exp_ferr); end
    endtask

    task automatic test_reset_mid();
        logic [9:0] act, exp;
        sb.delete();
        for (int c = 0; c < 3000; c++) frame_bit(1, 1'b1, c, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        sync_in = 1'b0;
        #1;
        n_vec += 6;
        if (bus.byte_out !== 8'h00) begin n_err++; $display("FAIL rstmid_byte_out: got %h, required 00", bus.byte_out); end
        if (bus.byte_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_valid: got %b, required 0", bus.byte_valid); end
        if (bus.byte_sop !== 1'b0) begin n_err++; $display("FAIL rstmid_sop: got %b, required 0", bus.byte_sop); end
        if (bus.byte_eop !== 1'b0) begin n_err++; $display("FAIL rstmid_eop: got %b, required 0", bus.byte_eop); end
        if (ovf !== 1'b0) begin n_err++; $display("FAIL rstmid_ovf: got %b, required 0", ovf); end
        if (frame_err !== 1'b0) begin n_err++; $display("FAIL rstmid_frame_err: got %b, required 0", frame_err); end
        sb.delete();
        repeat (3) @(negedge clk);
        #1 reset_n = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        n_vec++;
        if (bus.byte_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_empty: got valid %b, required 0", bus.byte_valid); end
        n_rx = 0;
        for (int c = 0; c < LDPC_N + 20; c++) begin
            if (c < LDPC_N) frame_bit(1, 1'b0, c, 1'b1, 1'b1);
            else            drive(1'b0, 1'b0, 1'b0, 1'b1);
            if (bus.byte_valid === 1'b1 && bus.byte_ready === 1'b1) begin
                act = {bus.byte_sop, bus.byte_eop, bus.byte_out};
                n_vec++;
                n_rx++;
                if (sb.size() == 0) begin
                    n_err++; $display("FAIL rstmid_byte: got %h, required no byte", act);
                end else begin
                    exp = sb.pop_front();
                    if (act !== exp) begin n_err++; $display("FAIL rstmid_byte #%0d: got %h, required %h", n_rx - 1, act, exp); end
                end
            end
        end
        n_vec += 2;
        if (n_rx !== 576) begin n_err++; $display("FAIL rstmid_count: got %0d, required 576", n_rx); end
        if (sb.size() !== 0) begin n_err++; $display("FAIL rstmid_pending: got %0d left, required 0", sb.size()); end
    endtask

    initial begin
        test_reset();
        test_rate0();
        test_rate1();
        test_back_to_back();
        test_overflow();
        test_abort();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
